// File: rtl/cache_ctrl_param.sv
// ============================================================================
// cache_ctrl_param
// ----------------------------------------------------------------------------
// Purpose:
//   Direct-mapped, write-back, write-allocate cache controller. A CPU request
//   is captured in IDLE, looked up in COMPARE, and on a miss the victim line is
//   written back (if dirty) before the new block is fetched and the lookup is
//   repeated.
//
// Parameters:
//   ADDR_W        byte-address width
//   WORD_W        CPU word width (multiple of 8)
//   WORDS_PER_BLK words per cache line (power of 2)
//   NUM_LINES     number of lines (power of 2)
//
// Optional feature macro:
//   CACHE_PERF_CNT_EN  builds saturating hit/miss/writeback counters; when
//                      undefined the counter ports are tied to zero.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cpu_req/cpu_we             request strobe (sampled in IDLE) / write enable
//   cpu_addr/cpu_wdata         byte address / write data
//   cpu_ready/cpu_hit          completion pulse / first-lookup hit flag
//   cpu_rdata                  read data, held until the next completion
//   mem_rd_req/mem_wr_req      block read / block write request
//   mem_addr                   block-aligned memory address
//   mem_wdata/mem_rdata        block data out / in
//   mem_ack                    one-cycle completion of the memory request
//   hit_cnt/miss_cnt/wb_cnt    performance counters
// ============================================================================
module cache_ctrl_param #(
    parameter int ADDR_W        = 16,
    parameter int WORD_W        = 32,
    parameter int WORDS_PER_BLK = 8,
    parameter int NUM_LINES     = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [WORD_W-1:0]               cpu_wdata,
    output logic                            cpu_ready,
    output logic                            cpu_hit,
    output logic [WORD_W-1:0]               cpu_rdata,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [WORD_W*WORDS_PER_BLK-1:0] mem_wdata,
    input  logic [WORD_W*WORDS_PER_BLK-1:0] mem_rdata,
    input  logic                            mem_ack,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt,
    output logic [31:0]                     wb_cnt
);

    localparam int BLK_W  = WORD_W * WORDS_PER_BLK;
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int OFF_W  = $clog2(WORDS_PER_BLK * WORD_W / 8);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WSEL_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [WORD_W-1:0]    r_wdata;
    logic                 r_refill;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    logic [TAG_W-1:0]     r_tagArr  [NUM_LINES];
    logic [BLK_W-1:0]     r_dataArr [NUM_LINES];

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [WSEL_W-1:0]    w_wordSel;
    logic [BLK_W-1:0]     w_line;
    logic [TAG_W-1:0]     w_lineTag;
    logic                 w_hit;
    logic                 w_victimDirty;
    logic [WORD_W-1:0]    w_word;
    logic [BLK_W-1:0]     w_lineUpd;
    logic [ADDR_W-1:0]    w_reqBlkAddr;
    logic [ADDR_W-1:0]    w_victimAddr;
    logic                 w_unusedBits;

    // Address split of the captured request; byte-within-word bits are dropped.
    assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = r_addr[OFF_W +: IDX_W];

    generate
        if (WORDS_PER_BLK > 1) begin : g_wordSel
            assign w_wordSel = r_addr[BYTE_W +: WSEL_W];
        end else begin : g_noWordSel
            assign w_wordSel = '0;
        end
    endgenerate

    // Only reduced so the byte-offset bits of r_addr count as consumed.
    assign w_unusedBits = ^r_addr;

    assign w_line        = r_dataArr[w_idx];
    assign w_lineTag     = r_tagArr[w_idx];
    assign w_hit         = r_valid[w_idx] && (w_lineTag == w_tag);
    assign w_victimDirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_word        = w_line[int'(w_wordSel)*WORD_W +: WORD_W];
    assign w_reqBlkAddr  = {w_tag, w_idx, {OFF_W{1'b0}}};
    assign w_victimAddr  = {w_lineTag, w_idx, {OFF_W{1'b0}}};

    // The addressed line with only the selected word replaced by write data.
    always_comb begin
        w_lineUpd = w_line;
        w_lineUpd[int'(w_wordSel)*WORD_W +: WORD_W] = r_wdata;
    end

    // Main FSM with registered outputs. cpu_ready/cpu_hit are one-cycle
    // pulses; the memory request and its address/data stay stable until
    // mem_ack, and a write-back hands over directly to the block read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_refill   <= 1'b0;
            r_valid    <= '0;
            r_dirty    <= '0;
            cpu_ready  <= 1'b0;
            cpu_hit    <= 1'b0;
            cpu_rdata  <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_addr   <= cpu_addr;
                        r_we     <= cpu_we;
                        r_wdata  <= cpu_wdata;
                        r_refill <= 1'b0;
                        r_state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= !r_refill;
                        cpu_rdata <= r_we ? r_wdata : w_word;
                        if (r_we) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (w_victimDirty) begin
                        mem_wr_req <= 1'b1;
                        mem_addr   <= w_victimAddr;
                        mem_wdata  <= w_line;
                        r_state    <= WRITEBACK;
                    end else begin
                        mem_rd_req <= 1'b1;
                        mem_addr   <= w_reqBlkAddr;
                        r_state    <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_wr_req     <= 1'b0;
                        mem_rd_req     <= 1'b1;
                        mem_addr       <= w_reqBlkAddr;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        mem_rd_req     <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_refill       <= 1'b1;
                        r_state        <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag and data storage are not reset. Writes are qualified by r_state,
    // which reset forces to IDLE, so an aborted refill never touches a line.
    always_ff @(posedge clk) begin
        if (r_state == COMPARE && w_hit && r_we) begin
            r_dataArr[w_idx] <= w_lineUpd;
        end else if (r_state == ALLOCATE && mem_ack) begin
            r_dataArr[w_idx] <= mem_rdata;
            r_tagArr[w_idx]  <= w_tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;
    logic [31:0] r_wbCnt;

    // Saturating counters. A lookup after a refill is not a first lookup, so
    // it counts neither as hit nor as miss.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hitCnt  <= '0;
            r_missCnt <= '0;
            r_wbCnt   <= '0;
        end else begin
            if (r_state == COMPARE && !r_refill) begin
                if (w_hit && r_hitCnt != 32'hFFFF_FFFF) begin
                    r_hitCnt <= r_hitCnt + 32'd1;
                end
                if (!w_hit && r_missCnt != 32'hFFFF_FFFF) begin
                    r_missCnt <= r_missCnt + 32'd1;
                end
            end
            if (r_state == WRITEBACK && mem_ack && r_wbCnt != 32'hFFFF_FFFF) begin
                r_wbCnt <= r_wbCnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hitCnt;
    assign miss_cnt = r_missCnt;
    assign wb_cnt   = r_wbCnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign wb_cnt   = '0;
`endif

endmodule
